// File: rtl/mul_pkg.sv
// Shared constants and the stage payload for the pipelined signed multiplier.
//   W_IN    operand width (signed)
//   W_OUT   product width kept on P (2*W_IN-1; exact product is truncated)
//   LAT     enabled edges from operand capture to product on P
//   stage_t payload carried between pipeline stages: running sum plus both operands
package mul_pkg;

  localparam int W_IN  = 13;
  localparam int W_OUT = 2 * W_IN - 1;
  localparam int LAT   = W_IN + 1;

  typedef struct packed {
    logic [W_OUT-1:0] acc;
    logic [W_IN-1:0]  a;
    logic [W_IN-1:0]  b;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/mul_pp_stage.sv
// One radix-2 partial-product stage. Retires multiplier bit STAGE_IDX: adds
// sext(a) << STAGE_IDX into the running sum when that bit is set. The stage
// that handles the operand sign bit (IS_SIGN) subtracts instead, which is what
// gives two's-complement weighting to the multiplier MSB.
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, clears the registered payload
//   i_en  in   advance enable; payload holds when low
//   i_d   in   payload (stage_t) from the previous stage
//   o_q   out  registered payload for the next stage
module mul_pp_stage
  import mul_pkg::*;
#(
  parameter int STAGE_IDX = 0,
  parameter bit IS_SIGN   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [STAGE_W-1:0] i_d,
  output logic [STAGE_W-1:0] o_q
);

  stage_t           w_d;
  stage_t           w_next;
  stage_t           r_q;
  logic [W_OUT-1:0] w_addend;

  assign w_d = stage_t'(i_d);

  // Sign-extend the multiplicand to the product width before shifting; any
  // bits pushed past W_OUT are dropped, which is the intended mod-2^W_OUT math.
  assign w_addend = {{(W_OUT-W_IN){w_d.a[W_IN-1]}}, w_d.a} << STAGE_IDX;

  always_comb begin
    w_next = w_d;
    if (w_d.b[STAGE_IDX]) begin
      w_next.acc = IS_SIGN ? (w_d.acc - w_addend) : (w_d.acc + w_addend);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/binary_mul_13_1_bi.sv
// Fully pipelined signed 13x13 multiplier, throughput one pair per enabled
// cycle, fixed latency of LAT enabled edges (input register + 13 bit stages).
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   en     in   global pipeline advance; every register, P included, holds when low
//   A      in   signed multiplicand
//   B      in   signed multiplier
//   P      out  low W_OUT bits of A*B, registered (output of the last stage)
// There is no valid output: the pipeline carries zeros out of reset, so P
// reads 0 until the first captured pair has advanced LAT enabled edges.
module binary_mul_13_1_bi
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W_IN-1:0]  A,
  input  logic [W_IN-1:0]  B,
  output logic [W_OUT-1:0] P
);

  stage_t             r_stage0;
  logic [STAGE_W-1:0] w_pipe [0:W_IN];
  stage_t             w_last;
  logic               w_unused;

  // Operand capture; the running sum starts at zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stage0 <= '0;
    end else if (en) begin
      r_stage0 <= '{acc: '0, a: A, b: B};
    end
  end

  assign w_pipe[0] = r_stage0;

  for (genvar gi = 0; gi < W_IN; gi++) begin : g_stage
    mul_pp_stage #(
      .STAGE_IDX (gi),
      .IS_SIGN   (gi == W_IN - 1)
    ) u_stage (
      .clk  (clk),
      .rst  (rst_n),
      .i_en (en),
      .i_d  (w_pipe[gi]),
      .o_q  (w_pipe[gi+1])
    );
  end

  assign w_last = stage_t'(w_pipe[W_IN]);
  assign P      = w_last.acc;

  // Operands are no longer needed once the sign bit has been retired.
  assign w_unused = ^{w_last.a, w_last.b};

endmodule

// File: tb/tb_binary_mul_13_1_bi.sv
// Bench for binary_mul_13_1_bi. Drivers push expected products into exp_q as
// pairs are issued; a negedge monitor pops and compares whenever a scored
// pair reaches the output, and checks P is zero in and out of reset and
// frozen during stalls.
module tb_binary_mul_13_1_bi;
  import mul_pkg::*;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [W_IN-1:0]  A   = '0;
  logic [W_IN-1:0]  B   = '0;
  logic [W_OUT-1:0] P;

  always #5 clk = ~clk;

  binary_mul_13_1_bi dut (
    .clk   (clk),
    .rst_n (rst),
    .en    (en),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  // ---------------- scoreboard state ----------------
  logic [W_OUT-1:0] exp_q[$];
  int               tests = 0;
  int               fails = 0;
  logic             drv_valid = 1'b0;
  logic [LAT-1:0]   vld_sr;
  logic             shifted;
  logic [W_OUT-1:0] last_p = '0;
  logic             have_last = 1'b0;
  logic             data_seen = 1'b0;

  // Tracks which enabled edge delivers a scored pair: a pair issued on an
  // enabled edge is on P after LAT enabled edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      shifted <= 1'b0;
    end else begin
      shifted <= en;
      if (en) vld_sr <= {vld_sr[LAT-2:0], drv_valid};
    end
  end

  task automatic check(input string name, input logic [W_OUT-1:0] act,
                       input logic [W_OUT-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
               name, $signed(act), act, $signed(req), req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("reset_zero", P, '0);
      have_last = 1'b0;
      data_seen = 1'b0;
    end else if (shifted) begin
      if (vld_sr[LAT-1]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow: got 0x%h with no expected value", P);
        end else begin
          check("product", P, exp_q.pop_front());
        end
        data_seen = 1'b1;
      end else if (!data_seen) begin
        check("zero_before_data", P, '0);
      end
    end else if (have_last) begin
      check("stall_hold", P, last_p);
    end
    if (!rst) begin
      last_p    = P;
      have_last = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input logic valid);
    A         = W_IN'(a);
    B         = W_IN'(b);
    en        = 1'b1;
    drv_valid = valid;
    step();
  endtask

  task automatic issue(input int a, input int b, input int expv);
    exp_q.push_back(W_OUT'(expv));
    drive(a, b, 1'b1);
  endtask

  task automatic stall(input int n);
    en        = 1'b0;
    drv_valid = 1'b0;
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ra;
    int rb;

    // 1. reset with toggling inputs, then 3*5
    #2 rst = 1'b1;
    repeat (10) begin
      A  = W_IN'($urandom);
      B  = W_IN'($urandom);
      en = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    repeat (LAT) issue(3, 5, 15);

    // 2. sign corners, each held for LAT edges
    repeat (LAT) issue(4095, 4095, 16769025);
    repeat (LAT) issue(-4096, 4095, -16773120);
    repeat (LAT) issue(-1, -1, 1);
    repeat (LAT) issue(0, -4096, 0);
    repeat (LAT) issue(-4096, -4096, 32'h0100_0000);

    // 3. streaming, a new pair every edge
    for (int i = 1; i <= 20; i++) issue(i, -i, -(i * i));

    // 4. stall mid-flight
    issue(7, 9, 63);
    issue(-2, 100, -200);
    stall(5);
    repeat (LAT) drive(0, 0, 1'b0);

    // 5. mid-flight reset: get P nonzero, load 100*-100, reset on its 6th edge
    issue(11, 11, 121);
    repeat (LAT - 1) drive(11, 11, 1'b0);
    drive(100, -100, 1'b0);
    repeat (4) drive(11, 11, 1'b0);
    A = '0;
    B = '0;
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("async_reset", P, '0);
    step();
    rst = 1'b0;
    repeat (LAT + 6) drive(0, 0, 1'b0);

    // 6. random pipelined streaming with occasional stalls
    for (int i = 0; i < 200; i++) begin
      ra = int'($urandom_range(0, 8191)) - 4096;
      rb = int'($urandom_range(0, 8191)) - 4096;
      issue(ra, rb, ra * rb);
      if ($urandom_range(0, 9) == 0) stall(int'($urandom_range(1, 3)));
    end
    repeat (LAT + 2) drive(0, 0, 1'b0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_empty: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
